// File: rtl/tbm_tx_4b5b.sv
// -----------------------------------------------------------------------------
// tbm_tx_4b5b
//   Serial 4b/5b NRZI frame transmitter. Nibbles arrive over a valid/ready
//   handshake. Each frame goes out as J K <data symbols> T R, and idle symbols
//   (11111) fill the gaps between frames. One line bit leaves per clock on sdata.
//   Symbols are sent MSB first, one symbol every 5 clocks.
//
// Parameters
//   IDLE_GAP  minimum number of complete idle symbols between R and the next J
//             (1..15)
//   NRZI      1 = NRZI line coding (toggle on 1), 0 = plain NRZ for debug
//
// Ports
//   clk        bit clock, one serial bit per rising edge
//   reset      asynchronous, active-high reset
//   din        data nibble
//   din_first  nibble opens a frame (qualified by din_valid)
//   din_last   nibble closes a frame (may be set together with din_first)
//   din_valid  din / flags valid
//   din_ready  nibble is accepted at this rising edge (symbol boundary only)
//   sdata      registered serial line output
//   busy       frame in progress (state not IDLE)
//   err        sticky protocol error; cleared only by reset
// -----------------------------------------------------------------------------
module tbm_tx_4b5b #(
    parameter int IDLE_GAP = 2,
    parameter bit NRZI     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       din_first,
    input  logic       din_last,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       sdata,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J,
        ST_K,
        ST_DATA,
        ST_T,
        ST_R
    } state_t;

    localparam logic [4:0] SYM_IDLE = 5'b11111;
    localparam logic [4:0] SYM_J    = 5'b11000;
    localparam logic [4:0] SYM_K    = 5'b10001;
    localparam logic [4:0] SYM_T    = 5'b01101;
    localparam logic [4:0] SYM_R    = 5'b00111;

    localparam logic [3:0] GAP_MIN  = 4'(IDLE_GAP);
    localparam logic [2:0] LAST_BIT = 3'd4;

    function automatic logic [4:0] enc(input logic [3:0] nib);
        logic [4:0] code;
        case (nib)
            4'h0: code = 5'b11110;
            4'h1: code = 5'b01001;
            4'h2: code = 5'b10100;
            4'h3: code = 5'b10101;
            4'h4: code = 5'b01010;
            4'h5: code = 5'b01011;
            4'h6: code = 5'b01110;
            4'h7: code = 5'b01111;
            4'h8: code = 5'b10010;
            4'h9: code = 5'b10011;
            4'hA: code = 5'b10110;
            4'hB: code = 5'b10111;
            4'hC: code = 5'b11010;
            4'hD: code = 5'b11011;
            4'hE: code = 5'b11100;
            default: code = 5'b11101;
        endcase
        return code;
    endfunction

    state_t     state;
    logic [4:0] sym;
    logic [2:0] bitcnt;
    logic [3:0] hold_nib;
    logic       hold_last;
    logic [3:0] gap_cnt;

    logic [4:0] sym_shift;
    logic       raw_bit;
    logic       boundary;
    logic       xfer;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        sym_shift = sym << bitcnt;
        raw_bit   = sym_shift[4];
        boundary  = (bitcnt == LAST_BIT);
        din_ready = 1'b0;
        if (boundary) begin
            if (state == ST_IDLE && gap_cnt >= GAP_MIN)
                din_ready = 1'b1;
            else if (state == ST_DATA && !hold_last)
                din_ready = 1'b1;
        end
        xfer = din_valid && din_ready;
        busy = (state != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and block ordering cannot matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sym       <= SYM_IDLE;
            bitcnt    <= 3'd0;
            gap_cnt   <= GAP_MIN;
            // NOTE: the hold registers are reset even though they are always
            // written before use; this keeps X out of simulation at no cost.
            hold_nib  <= 4'd0;
            hold_last <= 1'b0;
            sdata     <= 1'b0;
            err       <= 1'b0;
        end else begin
            sdata <= NRZI ? (sdata ^ raw_bit) : raw_bit;

            if (!boundary) begin
                bitcnt <= bitcnt + 3'd1;
            end else begin
                bitcnt <= 3'd0;
                case (state)
                    ST_IDLE: begin
                        if (xfer && din_first) begin
                            hold_nib  <= din;
                            hold_last <= din_last;
                            state     <= ST_J;
                            sym       <= SYM_J;
                        end else begin
                            // A nibble without din_first cannot open a frame;
                            // it is dropped and the idle pattern continues.
                            if (xfer)
                                err <= 1'b1;
                            sym <= SYM_IDLE;
                            if (gap_cnt != 4'd15)
                                gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    ST_J: begin
                        state <= ST_K;
                        sym   <= SYM_K;
                    end
                    ST_K: begin
                        state <= ST_DATA;
                        sym   <= enc(hold_nib);
                    end
                    ST_DATA: begin
                        if (hold_last) begin
                            state <= ST_T;
                            sym   <= SYM_T;
                        end else if (xfer) begin
                            sym       <= enc(din);
                            hold_last <= din_last;
                            if (din_first)
                                err <= 1'b1;
                        end else begin
                            // Underrun: close the frame early rather than
                            // stall the line with a bubble.
                            state <= ST_T;
                            sym   <= SYM_T;
                            err   <= 1'b1;
                        end
                    end
                    ST_T: begin
                        state <= ST_R;
                        sym   <= SYM_R;
                    end
                    ST_R: begin
                        // The idle symbol loaded here is the first of the gap.
                        state   <= ST_IDLE;
                        sym     <= SYM_IDLE;
                        gap_cnt <= 4'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        sym   <= SYM_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tbm_tx_4b5b.sv
// -----------------------------------------------------------------------------
// tb_tbm_tx_4b5b
//   Bench for tbm_tx_4b5b (IDLE_GAP=2, NRZI=1). The reference is a symbol-level
//   picture of the line: a queue with one entry per 5-clock symbol slot since
//   reset release (symbol code, whether din_ready may pulse in that slot, and
//   the expected err level). Each clock the expected line bit is taken from
//   that queue and NRZI-accumulated; busy, err and din_ready are derived from
//   the slot the block is in after the edge.
// -----------------------------------------------------------------------------
module tb_tbm_tx_4b5b;

    localparam int G = 2;

    localparam logic [4:0] S_IDLE = 5'b11111;
    localparam logic [4:0] S_J    = 5'b11000;
    localparam logic [4:0] S_K    = 5'b10001;
    localparam logic [4:0] S_T    = 5'b01101;
    localparam logic [4:0] S_R    = 5'b00111;
    localparam logic [4:0] ENC_TAB [16] = '{
        5'b11110, 5'b01001, 5'b10100, 5'b10101,
        5'b01010, 5'b01011, 5'b01110, 5'b01111,
        5'b10010, 5'b10011, 5'b10110, 5'b10111,
        5'b11010, 5'b11011, 5'b11100, 5'b11101
    };

    typedef struct packed {
        logic [4:0] sym;
        logic       rdy;
        logic       err;
    } slot_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       first;
        logic       last;
    } offer_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       din_first;
    logic       din_last;
    logic       din_valid;
    logic       din_ready;
    logic       sdata;
    logic       busy;
    logic       err;

    slot_t      slots[$];
    offer_t     offers[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         run_len = 0;
    logic       exp_line = 1'b0;
    logic       cur_err = 1'b0;

    always #5 clk = ~clk;

    tbm_tx_4b5b #(.IDLE_GAP(G), .NRZI(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_first (din_first),
        .din_last  (din_last),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sdata     (sdata),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // ---- reference model: symbol slots ------------------------------------
    task automatic m_push(input logic [4:0] s, input logic r);
        slots.push_back(slot_t'{sym: s, rdy: r, err: cur_err});
    endtask

    // Idle symbols; din_ready may pulse once at least G idles have been sent.
    task automatic m_idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (run_len < 15) run_len++;
            m_push(S_IDLE, run_len >= G);
        end
    endtask

    // A well-formed frame: model slots plus the offers that produce it.
    task automatic add_frame(input logic [3:0] q[$]);
        m_push(S_J, 1'b0);
        m_push(S_K, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            offers.push_back(offer_t'{nib: q[i], first: (i == 0), last: (i == q.size() - 1)});
            m_push(ENC_TAB[q[i]], i != q.size() - 1);
        end
        m_push(S_T, 1'b0);
        m_push(S_R, 1'b0);
        run_len = 0;
    endtask

    // ---- clocking and per-edge checks --------------------------------------
    task automatic step();
        int s;
        int b;
        int s2;
        logic [4:0] cur;
        @(posedge clk);
        #1;
        cyc++;
        s = (cyc - 1) / 5;
        b = (cyc - 1) % 5;
        if (s < slots.size()) begin
            cur = slots[s].sym;
            exp_line = exp_line ^ cur[4 - b];
            check("sdata", sdata, exp_line);
        end
        s2 = cyc / 5;
        if (s2 < slots.size()) begin
            check("busy", busy, slots[s2].sym != S_IDLE);
            check("err", err, slots[s2].err);
            check("din_ready", din_ready, (cyc % 5 == 4) && slots[s2].rdy);
        end
    endtask

    task automatic run_until(input int target);
        logic took;
        while (cyc < target) begin
            if (offers.size() > 0) begin
                din_valid = 1'b1;
                din       = offers[0].nib;
                din_first = offers[0].first;
                din_last  = offers[0].last;
            end else begin
                din_valid = 1'b0;
                din       = 4'h0;
                din_first = 1'b0;
                din_last  = 1'b0;
            end
            took = din_valid && din_ready;
            step();
            if (took) void'(offers.pop_front());
        end
    endtask

    task automatic run_phase(input string tag);
        run_until(5 * slots.size());
        check({tag, "_offers_left"}, offers.size(), 0);
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din       = 4'h0;
        din_first = 1'b0;
        din_last  = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sdata", sdata, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", din_ready, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        slots.delete();
        offers.delete();
        cyc      = 0;
        exp_line = 1'b0;
        cur_err  = 1'b0;
        run_len  = G - 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] q[$];

        // Reset, then 40 clocks with no offers: a continuous idle pattern.
        do_reset();
        m_idle(8);
        run_phase("idle40");

        // Single-nibble frame 0x5.
        m_idle(1);
        q = {4'h5};
        add_frame(q);
        m_idle(G);
        run_phase("single5");

        // Frame 0x0..0xF with din_valid held: no idle inside the frame.
        m_idle(1);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(4'(i));
        add_frame(q);
        m_idle(G);
        run_phase("seq0F");

        // Four random frames offered back-to-back: exactly G idles between.
        m_idle(1);
        for (int f = 0; f < 4; f++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 5)); i++)
                q.push_back(4'($urandom_range(0, 15)));
            add_frame(q);
            m_idle(G);
        end
        run_phase("b2b_rand");

        // Underrun: a single non-last nibble, then nothing -> J K 3 T R, err.
        m_idle(1);
        m_push(S_J, 1'b0);
        m_push(S_K, 1'b0);
        offers.push_back(offer_t'{nib: 4'h3, first: 1'b1, last: 1'b0});
        m_push(ENC_TAB[3], 1'b1);
        cur_err = 1'b1;
        m_push(S_T, 1'b0);
        m_push(S_R, 1'b0);
        run_len = 0;
        m_idle(G);
        run_phase("underrun");

        // Reset asserted mid-frame, away from any clock edge.
        m_idle(1);
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(4'($urandom_range(0, 15)));
        add_frame(q);
        run_until(cyc + 18);
        #2;
        reset = 1'b1;
        #1;
        check("async_sdata", sdata, 1'b0);
        check("async_busy", busy, 1'b0);
        check("async_err", err, 1'b0);
        check("async_ready", din_ready, 1'b0);
        do_reset();

        // din_first repeated mid-frame: err, nibble still sent as data.
        m_idle(1);
        m_push(S_J, 1'b0);
        m_push(S_K, 1'b0);
        offers.push_back(offer_t'{nib: 4'hA, first: 1'b1, last: 1'b0});
        m_push(ENC_TAB[10], 1'b1);
        cur_err = 1'b1;
        offers.push_back(offer_t'{nib: 4'hB, first: 1'b1, last: 1'b0});
        m_push(ENC_TAB[11], 1'b1);
        offers.push_back(offer_t'{nib: 4'hC, first: 1'b0, last: 1'b1});
        m_push(ENC_TAB[12], 1'b0);
        m_push(S_T, 1'b0);
        m_push(S_R, 1'b0);
        run_len = 0;
        m_idle(G);
        run_phase("midfirst");

        // Nibble without din_first while idle: dropped, err, idles continue;
        // a random frame queued right behind it still goes out normally.
        do_reset();
        m_idle(1);
        offers.push_back(offer_t'{nib: 4'h7, first: 1'b0, last: 1'b0});
        cur_err = 1'b1;
        m_idle(1);
        q.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++)
            q.push_back(4'($urandom_range(0, 15)));
        add_frame(q);
        m_idle(G);
        run_phase("nofirst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
